alarm_sweep_checker: RTL and testbench



---
 rtl/alarm_sweep_checker.sv | 156 +++++++++++++++
 tb/tb_alarm_sweep_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sweep_checker.sv
// alarm_sweep_checker
//   Self-test sequencer for a 3-input alarm function. Sweeps {A,B,C} through
//   0..7 in ascending order, holds each vector SETTLE cycles, samples the
//   alarm output on the following SAMPLE cycle, and compares the captured
//   8-entry truth table with EXPECTED.
//
// Parameters
//   EXPECTED   expected truth table, bit i = Y for ABC = i (A is the MSB)
//   SETTLE     cycles ABC is held before Y is sampled (1..15)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      sweep request, only looked at in IDLE
//   y          alarm output under test (synchronous to clk)
//   abc        stimulus {A,B,C} to the alarm implementation
//   busy       high from the cycle after start is accepted until DONE
//   done       one-cycle pulse; results valid from this cycle on
//   pass       captured table equals EXPECTED
//   tt         captured truth table
//   mismatch   tt ^ EXPECTED
//   first_fail lowest index set in mismatch, 0 when pass
//   fsm_state  current controller state (0 IDLE, 1 SETTLE, 2 SAMPLE, 3 DONE)
//
// Handshake: start is a level request with no queuing. It is accepted on a
// rising edge where the controller is in IDLE and start is 1; at any other
// time it is ignored. Holding start high re-arms a new sweep on the first
// IDLE cycle after DONE.
module alarm_sweep_checker #(
    parameter logic [7:0]  EXPECTED = 8'b1110_1000,
    parameter int unsigned SETTLE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic [2:0] abc,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] tt,
    output logic [7:0] mismatch,
    output logic [2:0] first_fail,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;

    // Table as it will look once the current SAMPLE cycle writes its bit.
    // The final verdict is registered from this on the last sampling edge so
    // that pass/mismatch/first_fail are already valid in the done cycle.
    logic [7:0] tt_final;
    logic [7:0] mm_final;
    logic [2:0] ff_final;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    always_comb begin
        tt_final      = tt;
        tt_final[abc] = y;
        mm_final      = tt_final ^ EXPECTED;
        ff_final      = lowest_set(mm_final);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == CNT_LAST) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = (abc == 3'd7) ? S_DONE : S_SETTLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    assign fsm_state = state;

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abc        <= 3'd0;
            cnt        <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            tt         <= 8'd0;
            mismatch   <= 8'd0;
            first_fail <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        abc        <= 3'd0;
                        cnt        <= 4'd0;
                        busy       <= 1'b1;
                        pass       <= 1'b0;
                        tt         <= 8'd0;
                        mismatch   <= 8'd0;
                        first_fail <= 3'd0;
                    end
                end
                S_SETTLE: begin
                    // Counter never wraps: at most 15 increments in 4 bits.
                    cnt <= cnt + 4'd1;
                end
                S_SAMPLE: begin
                    tt <= tt_final;
                    if (abc == 3'd7) begin
                        // abc stays at 7 until the next accepted start.
                        mismatch   <= mm_final;
                        pass       <= (mm_final == 8'd0);
                        first_fail <= ff_final;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        abc <= abc + 3'd1;
                        cnt <= 4'd0;
                    end
                end
                S_DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_sweep_checker.sv
// Bench for alarm_sweep_checker: two instances (SETTLE=1 and SETTLE=3) are
// exercised one at a time. The alarm implementation is modelled as a truth
// table (majority function, optionally with inverted entries); expected
// results are derived from that table and the vector timing.
module tb_alarm_sweep_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_v    [2];
    logic       y_v        [2];
    logic [2:0] abc_v      [2];
    logic       busy_v     [2];
    logic       done_v     [2];
    logic       pass_v     [2];
    logic [7:0] tt_v       [2];
    logic [7:0] mm_v       [2];
    logic [2:0] ff_v       [2];
    logic [1:0] st_v       [2];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] maj;

    always #5 clk = ~clk;

    alarm_sweep_checker #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y(y_v[0]),
        .abc(abc_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .tt(tt_v[0]), .mismatch(mm_v[0]), .first_fail(ff_v[0]),
        .fsm_state(st_v[0])
    );

    alarm_sweep_checker #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y(y_v[1]),
        .abc(abc_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .tt(tt_v[1]), .mismatch(mm_v[1]), .first_fail(ff_v[1]),
        .fsm_state(st_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk_results(input int d, input logic [7:0] impl);
        chk("tt",         32'(tt_v[d]), 32'(impl));
        chk("mismatch",   32'(mm_v[d]), 32'(impl ^ maj));
        chk("pass",       32'(pass_v[d]), 32'(impl == maj));
        chk("first_fail", 32'(ff_v[d]), 32'(lowest(impl ^ maj)));
    endtask

    task automatic chk_idle_zero(input int d);
        chk("rst_abc",   32'(abc_v[d]), 32'd0);
        chk("rst_busy",  32'(busy_v[d]), 32'd0);
        chk("rst_done",  32'(done_v[d]), 32'd0);
        chk("rst_pass",  32'(pass_v[d]), 32'd0);
        chk("rst_tt",    32'(tt_v[d]), 32'd0);
        chk("rst_mm",    32'(mm_v[d]), 32'd0);
        chk("rst_ff",    32'(ff_v[d]), 32'd0);
        chk("rst_state", 32'(st_v[d]), 32'd0);
    endtask

    // One complete sweep on instance d with the implementation behaving as
    // table impl. glitch: y is random outside sampling cycles. poke: start
    // pulsed at cycles 3 and 9 and during DONE. hold: start left high from
    // DONE on. armed: start is already high, so acceptance is the next edge.
    task automatic sweep(input int d, input logic [7:0] impl, input bit glitch,
                         input bit poke, input bit hold, input bit armed);
        int p;
        int vec;
        logic [7:0] mask;
        p = (d == 0) ? 2 : 4;
        if (!armed) begin
            @(negedge clk);
            start_v[d] = 1'b1;
        end
        @(posedge clk);   // accept edge
        for (int n = 0; n < 8 * p; n++) begin
            @(negedge clk);
            start_v[d] = poke && (n == 3 || n == 9);
            vec = n / p;
            if (!glitch || (n % p) == p - 1) y_v[d] = impl[vec];
            else                             y_v[d] = 1'($urandom_range(0, 1));
            mask = 8'd0;
            for (int j = 0; j < 8; j++) begin
                if ((j + 1) * p <= n) mask[j] = 1'b1;
            end
            chk("sw_abc",     32'(abc_v[d]), 32'(vec));
            chk("sw_busy",    32'(busy_v[d]), 32'd1);
            chk("sw_done",    32'(done_v[d]), 32'd0);
            chk("sw_tt_part", 32'(tt_v[d]), 32'(impl & mask));
            chk("sw_pass",    32'(pass_v[d]), 32'd0);
            chk("sw_mm",      32'(mm_v[d]), 32'd0);
        end
        @(negedge clk);   // DONE cycle: 8*p edges after accept
        start_v[d] = hold || poke;
        chk("dn_done", 32'(done_v[d]), 32'd1);
        chk("dn_busy", 32'(busy_v[d]), 32'd0);
        chk("dn_abc",  32'(abc_v[d]), 32'd7);
        chk_results(d, impl);
        @(negedge clk);   // IDLE cycle
        start_v[d] = hold;
        chk("id_done", 32'(done_v[d]), 32'd0);
        chk("id_busy", 32'(busy_v[d]), 32'd0);
        chk("id_abc",  32'(abc_v[d]), 32'd7);
        chk_results(d, impl);
        if (poke && !hold) begin
            @(negedge clk);
            chk("noq_busy", 32'(busy_v[d]), 32'd0);
            chk("noq_abc",  32'(abc_v[d]), 32'd7);
            chk_results(d, impl);
        end
    endtask

    task automatic reset_mid_sweep(input int d, input logic [7:0] impl);
        int p;
        p = (d == 0) ? 2 : 4;
        @(negedge clk);
        start_v[d] = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 4 * p; n++) begin
            @(negedge clk);
            start_v[d] = 1'b0;
            y_v[d] = impl[n / p];
        end
        @(negedge clk);
        chk("mr_abc_pre", 32'(abc_v[d]), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("mr_abc",  32'(abc_v[d]), 32'd0);
        chk("mr_busy", 32'(busy_v[d]), 32'd0);
        chk("mr_tt",   32'(tt_v[d]), 32'd0);
        chk("mr_done", 32'(done_v[d]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_zero(d);
    endtask

    initial begin
        logic [7:0] rnd;
        for (int i = 0; i < 8; i++) begin
            maj[i] = ((((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1)) >= 2);
        end
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            y_v[d]     = 1'b0;
        end

        // Reset and idle
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk_idle_zero(0);
            chk_idle_zero(1);
        end

        // Matching sweep and single fault at ABC=101 (SETTLE=1)
        sweep(0, maj, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("const_tt_e8", 32'(tt_v[0]), 32'hE8);
        sweep(0, maj ^ 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fault_tt_c8", 32'(tt_v[0]), 32'hC8);
        chk("fault_ff_5",  32'(ff_v[0]), 32'd5);

        // Longer settle with y toggling during SETTLE cycles
        sweep(1, maj, 1'b1, 1'b0, 1'b0, 1'b0);

        // start while busy, then start held high into a back-to-back sweep
        sweep(0, maj ^ 8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
        sweep(0, maj, 1'b0, 1'b1, 1'b1, 1'b0);
        sweep(0, maj ^ 8'h81, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized implementations on both instances
        for (int k = 0; k < 8; k++) begin
            rnd = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
            sweep(int'($urandom_range(0, 1)), maj ^ rnd,
                  1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-sweep, then a fresh sweep
        reset_mid_sweep(1, maj);
        sweep(1, maj, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_mid_sweep(0, maj ^ 8'h10);
        sweep(0, maj ^ 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "time limit reached");
    end

endmodule
